instr_encoder_loader: RTL and testbench
=======================================

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 Parameter DEPTH, default 256: instruction-memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-003 Signal clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Signal rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Signal start, input, 1: one-cycle pulse that begins a new load session.
REQ-006 Signal in_valid / in_ready, input / output, 1 each: field-tuple handshake; a transfer occurs when both are high on a clock edge.
REQ-007 Signal in_fmt, input, 3: instruction format; 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-008 Signals in_opcode (7), in_rd (5), in_funct3 (3), in_rs1 (5), in_rs2 (5), in_funct7 (7), in_imm (32), in_last (1), all inputs: instruction fields; in_last marks the final instruction of the session.
REQ-009 Signals mem_we (output, 1), mem_ready (input, 1), mem_addr (output, 32), mem_wdata (output, 32): instruction-memory write port; a write completes when mem_we and mem_ready are both high.
REQ-010 Signal count, output, $clog2(DEPTH)+1: words written in the current session.
REQ-011 Signals done and err, outputs, 1 each: session complete; sticky error.

Function
REQ-012 States: IDLE, LOAD, DONE. Reset enters IDLE. start moves IDLE or DONE to LOAD; start is ignored while in LOAD.
REQ-013 On entering LOAD, the write pointer is set to BASE_ADDR, and count, done and err are cleared.
REQ-014 R format encoding: funct7 | rs2 | rs1 | funct3 | rd | opcode.
REQ-015 I format encoding: imm[11:0] | rs1 | funct3 | rd | opcode.
REQ-016 S format encoding: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
REQ-017 B format encoding: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
REQ-018 U format encoding: imm[31:12] | rd | opcode.
REQ-019 J format encoding: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.
REQ-020 Unused fields are ignored; immediate bits above the format's range are discarded without error.
REQ-021 Encoding takes one register stage: a tuple accepted at edge N drives mem_we=1 with valid mem_addr and mem_wdata from edge N onward, and these hold stable until mem_ready is seen.
REQ-022 in_ready = (state==LOAD) and (output register empty, or mem_we and mem_ready in the same cycle) and count+pending < DEPTH; this gives full throughput of one word per cycle.
REQ-023 After each completed write, the write pointer advances by 4 and count increments by 1.
REQ-024 Error cases, each of which sets err and writes nothing:
  - illegal in_fmt;
  - B or J format with imm[0]=1.
  Handshake acceptance is unaffected, and in_last still applies.
REQ-025 After the write completing an in_last tuple, or the acceptance of an errored in_last tuple, the block moves to DONE and asserts done. in_ready=0 in DONE.
REQ-026 Capacity: when count reaches DEPTH without in_last, the block sets err and moves to DONE. The pointer never wraps.
REQ-027 mem_we is never asserted outside LOAD, except to drain a pending word before the block enters DONE.

Reset
REQ-028 rst_n low immediately clears every register, including mid-write. Reset values:
  - state IDLE;
  - in_ready, mem_we, done, err = 0;
  - count = 0;
  - mem_addr = BASE_ADDR;
  - mem_wdata = 0.
REQ-029 An in-flight word is discarded on reset and is not replayed.

Structure
REQ-030 A shared package holds:
  - the format enum (FMT_R..FMT_J);
  - the state enum;
  - the opcode constants (OP_OP=7'b0110011, OP_IMM=7'b0010011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011, OP_LUI=7'b0110111, OP_JAL=7'b1101111).
REQ-031 A combinational sub-module instr_field_packer maps fields and format to the 32-bit word and an illegal flag. It is instantiated once.

Verification
REQ-032 start; R add rd=3 rs1=1 rs2=2 f3=0 f7=0 op=0110011 -> mem_wdata=0x002081B3 at BASE_ADDR, count=1.
REQ-033 Back-to-back, mem_ready=1, the following five tuples, the last with in_last:
  - I addi x1,x0,5 -> 0x00500093;
  - S sw x2,8(x1) -> 0x0020A423;
  - B beq x1,x2,+8 -> 0x00208463;
  - U lui x5,0x12345 -> 0x123452B7;
  - J jal x1,+16 -> 0x010000EF.
  Required response: consecutive addresses BASE+0..BASE+16, one word per cycle, done=1, count=5.
REQ-034 mem_ready held low for 3 cycles -> mem_we, mem_addr and mem_wdata stay stable; in_ready=0 while a word is pending; no word is lost or duplicated.
REQ-035 B tuple with imm=0x7 and a tuple with in_fmt=6 -> err=1, no write, count unchanged; a following legal tuple is written to the next sequential address.
REQ-036 DEPTH=4 with 5 tuples offered -> 4 words written, then err=1, done=1, in_ready=0. rst_n pulsed low during a stalled write -> all outputs at reset values and the block in IDLE.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// instr_encoder_loader_pkg: shared format/state enums and base opcode constants
package instr_encoder_loader_pkg;
    typedef enum logic [2:0] {FMT_R = 3'd0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
endpackage

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: field-tuple stream in, instruction-memory write port out
//   in_*      : tuple handshake and fields (master drives, slave consumes)
//   mem_*     : memory write port (slave drives we/addr/wdata, master returns ready)
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
               in_funct7, in_imm, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
               in_funct7, in_imm, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational RV32 field-to-word packer with illegal flag
//   inputs: fmt, opcode, rd, funct3, rs1, rs2, funct7, imm
//   outputs: word (encoded instruction), illegal (bad format or odd B/J offset)
module instr_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    always_comb begin
        case (fmt)
            FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   word = {imm[31:12], rd, opcode};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = '0;
        endcase
        illegal = (fmt > 3'd5) || ((fmt == FMT_B || fmt == FMT_J) && imm[0]);
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes field tuples and streams them into instruction memory
//   clk, rst_n : clock, async active-low reset
//   start      : begins a load session from IDLE or DONE
//   bus        : tuple handshake + memory write port (slave modport)
//   count      : words written this session; done / err : session complete / sticky error
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   done,
    output logic                   err
);
    state_e      state;
    logic        pend_last;
    logic [31:0] word;
    logic        illegal;
    logic        accept;
    logic        fire;

    instr_field_packer u_packer (
        .fmt(bus.in_fmt), .opcode(bus.in_opcode), .rd(bus.in_rd), .funct3(bus.in_funct3),
        .rs1(bus.in_rs1), .rs2(bus.in_rs2), .funct7(bus.in_funct7), .imm(bus.in_imm),
        .word(word), .illegal(illegal)
    );

    // Output register may refill in the cycle it drains; no tuple is taken
    // behind a pending last word so nothing can spill into DONE.
    always_comb begin
        bus.in_ready = (state == LOAD) && (!bus.mem_we || bus.mem_ready)
                     && !(bus.mem_we && pend_last)
                     && (int'(count) + int'(bus.mem_we) < DEPTH);
        accept = bus.in_valid && bus.in_ready;
        fire   = bus.mem_we && bus.mem_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= '0;
            count         <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            pend_last     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (fire) begin
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= bus.mem_addr + 32'd4;
                        count        <= count + 1'b1;
                        if (pend_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (int'(count) + 1 == DEPTH) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                    if (accept) begin
                        if (illegal) begin
                            err <= 1'b1;
                            if (bus.in_last) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_wdata <= word;
                            pend_last     <= bus.in_last;
                        end
                    end
                end
                default: if (start) begin
                    state        <= LOAD;
                    bus.mem_addr <= BASE_ADDR;
                    count        <= '0;
                    done         <= 1'b0;
                    err          <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed self-checking bench (DEPTH=256 and DEPTH=4 instances)
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
    } tup_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic v_valid = 1'b0;
    logic v_last = 1'b0;
    logic mem_rdy = 1'b0;
    tup_t cur = '0;
    logic [8:0] count_a;
    logic [2:0] count_b;
    logic done_a, err_a, done_b, err_b;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    instr_encoder_loader_if a_if();
    instr_encoder_loader_if b_if();

    assign a_if.in_valid = v_valid;   assign b_if.in_valid = v_valid;
    assign a_if.in_last = v_last;     assign b_if.in_last = v_last;
    assign a_if.mem_ready = mem_rdy;  assign b_if.mem_ready = mem_rdy;
    assign a_if.in_fmt = cur.fmt;     assign b_if.in_fmt = cur.fmt;
    assign a_if.in_opcode = cur.op;   assign b_if.in_opcode = cur.op;
    assign a_if.in_rd = cur.rd;       assign b_if.in_rd = cur.rd;
    assign a_if.in_funct3 = cur.f3;   assign b_if.in_funct3 = cur.f3;
    assign a_if.in_rs1 = cur.rs1;     assign b_if.in_rs1 = cur.rs1;
    assign a_if.in_rs2 = cur.rs2;     assign b_if.in_rs2 = cur.rs2;
    assign a_if.in_funct7 = cur.f7;   assign b_if.in_funct7 = cur.f7;
    assign a_if.in_imm = cur.imm;     assign b_if.in_imm = cur.imm;

    instr_encoder_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_1000)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bus(a_if.slave),
        .count(count_a), .done(done_a), .err(err_a)
    );
    instr_encoder_loader #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bus(b_if.slave),
        .count(count_b), .done(done_b), .err(err_b)
    );

    // Write logs: every completed memory write with the cycle it happened in.
    logic [31:0] la_addr[32], la_data[32], lb_addr[32], lb_data[32];
    int la_cyc[32];
    int la_n = 0;
    int lb_n = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_if.mem_we && a_if.mem_ready && la_n < 32) begin
            la_addr[la_n] <= a_if.mem_addr;
            la_data[la_n] <= a_if.mem_wdata;
            la_cyc[la_n]  <= cyc;
            la_n          <= la_n + 1;
        end
        if (b_if.mem_we && b_if.mem_ready && lb_n < 32) begin
            lb_addr[lb_n] <= b_if.mem_addr;
            lb_data[lb_n] <= b_if.mem_wdata;
            lb_n          <= lb_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic tup_t tup(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [6:0] f7, input logic [31:0] imm);
        tup_t t;
        t = '{fmt, op, rd, f3, rs1, rs2, f7, imm};
        return t;
    endfunction

    // Offers one tuple; returns whether it was accepted within a bounded wait.
    task automatic send(input bit sel, input tup_t t, input bit last, output bit acc);
        cur = t;
        v_last = last;
        v_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 12 && !acc; i++) begin
            @(negedge clk);
            if (sel ? b_if.in_ready : a_if.in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        v_valid = 1'b0;
        v_last = 1'b0;
    endtask

    task automatic pulse(input bit sel);
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n0;
        tup_t t_r, t_i, t_s, t_b, t_u, t_j;
        logic [31:0] exp_d[5];
        t_r = tup(FMT_R, OP_OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
        t_i = tup(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        t_s = tup(FMT_S, OP_STORE, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
        t_b = tup(FMT_B, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8);
        t_u = tup(FMT_U, OP_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
        t_j = tup(FMT_J, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd16);
        exp_d = '{32'h00500093, 32'h0020A423, 32'h00208463, 32'h123452B7, 32'h010000EF};

        // Reset values
        #12;
        chk("rst_in_ready", a_if.in_ready, 0);
        chk("rst_mem_we", a_if.mem_we, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_mem_addr", a_if.mem_addr, 32'h1000);
        chk("rst_mem_wdata", a_if.mem_wdata, 0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single R-format word
        mem_rdy = 1'b1;
        pulse(0);
        send(0, t_r, 1'b1, acc);
        chk("r_acc", acc, 1);
        wait_cycles(2);
        chk("r_nwrites", la_n, 1);
        chk("r_addr", la_addr[0], 32'h1000);
        chk("r_data", la_data[0], 32'h002081B3);
        chk("r_count", count_a, 1);
        chk("r_done", done_a, 1);
        chk("r_err", err_a, 0);

        // Back-to-back I/S/B/U/J in a fresh session
        pulse(0);
        chk("s2_count_clr", count_a, 0);
        chk("s2_done_clr", done_a, 0);
        send(0, t_i, 1'b0, acc);
        chk("b2b_acc0", acc, 1);
        send(0, t_s, 1'b0, acc);
        chk("b2b_acc1", acc, 1);
        send(0, t_b, 1'b0, acc);
        chk("b2b_acc2", acc, 1);
        send(0, t_u, 1'b0, acc);
        chk("b2b_acc3", acc, 1);
        send(0, t_j, 1'b1, acc);
        chk("b2b_acc4", acc, 1);
        wait_cycles(2);
        chk("b2b_nwrites", la_n, 6);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("b2b_addr%0d", k), la_addr[1 + k], 32'h1000 + 32'(4 * k));
            chk($sformatf("b2b_data%0d", k), la_data[1 + k], exp_d[k]);
            chk($sformatf("b2b_cyc%0d", k), la_cyc[1 + k] - la_cyc[1], k);
        end
        chk("b2b_done", done_a, 1);
        chk("b2b_count", count_a, 5);
        chk("b2b_err", err_a, 0);

        // Stalled write: mem_ready low for 3 cycles
        pulse(0);
        n0 = la_n;
        mem_rdy = 1'b0;
        send(0, t_i, 1'b0, acc);
        chk("stall_acc", acc, 1);
        cur = t_s;
        v_last = 1'b1;
        v_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall_we%0d", k), a_if.mem_we, 1);
            chk($sformatf("stall_addr%0d", k), a_if.mem_addr, 32'h1000);
            chk($sformatf("stall_data%0d", k), a_if.mem_wdata, 32'h00500093);
            chk($sformatf("stall_rdy%0d", k), a_if.in_ready, 0);
        end
        chk("stall_nowrite", la_n, n0);
        mem_rdy = 1'b1;
        #1;
        chk("stall_refill_rdy", a_if.in_ready, 1);
        @(posedge clk);
        #1;
        v_valid = 1'b0;
        v_last = 1'b0;
        wait_cycles(2);
        chk("stall_nwrites", la_n, n0 + 2);
        chk("stall_addr_a", la_addr[n0], 32'h1000);
        chk("stall_data_a", la_data[n0], 32'h00500093);
        chk("stall_addr_b", la_addr[n0 + 1], 32'h1004);
        chk("stall_data_b", la_data[n0 + 1], 32'h0020A423);
        chk("stall_count", count_a, 2);
        chk("stall_done", done_a, 1);

        // Error tuples are consumed without writing
        pulse(0);
        n0 = la_n;
        send(0, t_r, 1'b0, acc);
        chk("err_acc_r", acc, 1);
        send(0, tup(FMT_B, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd7), 1'b0, acc);
        chk("err_acc_b", acc, 1);
        chk("err_b_flag", err_a, 1);
        send(0, tup(3'd6, OP_OP, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'd0), 1'b0, acc);
        chk("err_acc_f6", acc, 1);
        chk("err_count", count_a, 1);
        chk("err_nwrites", la_n, n0 + 1);
        send(0, t_i, 1'b1, acc);
        chk("err_acc_i", acc, 1);
        wait_cycles(2);
        chk("err_after_n", la_n, n0 + 2);
        chk("err_after_addr", la_addr[n0 + 1], 32'h1004);
        chk("err_after_data", la_data[n0 + 1], 32'h00500093);
        chk("err_after_count", count_a, 2);
        chk("err_sticky", err_a, 1);
        chk("err_done", done_a, 1);

        // Capacity limit on the DEPTH=4 instance
        pulse(1);
        for (int k = 0; k < 5; k++) begin
            send(1, tup(FMT_U, OP_LUI, 5'(k), 3'd0, 5'd0, 5'd0, 7'd0, 32'(k) << 12), 1'b0, acc);
            chk($sformatf("cap_acc%0d", k), acc, k < 4);
        end
        chk("cap_nwrites", lb_n, 4);
        chk("cap_last_addr", lb_addr[3], 32'h0000_000C);
        chk("cap_last_data", lb_data[3], 32'h0000_31B7);
        chk("cap_count", count_b, 4);
        chk("cap_err", err_b, 1);
        chk("cap_done", done_b, 1);
        chk("cap_in_ready", b_if.in_ready, 0);

        // Reset during a stalled write
        pulse(1);
        mem_rdy = 1'b0;
        send(1, t_u, 1'b0, acc);
        chk("rstw_acc", acc, 1);
        chk("rstw_pending", b_if.mem_we, 1);
        n0 = lb_n;
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_in_ready", b_if.in_ready, 0);
        chk("rstw_mem_we", b_if.mem_we, 0);
        chk("rstw_done", done_b, 0);
        chk("rstw_err", err_b, 0);
        chk("rstw_count", count_b, 0);
        chk("rstw_addr", b_if.mem_addr, 0);
        chk("rstw_wdata", b_if.mem_wdata, 0);
        chk("rstw_state", 32'(u_b.state), 32'(IDLE));
        #3 rst_n = 1'b1;
        mem_rdy = 1'b1;
        wait_cycles(3);
        chk("rstw_no_replay", lb_n, n0);
        chk("rstw_we_idle", b_if.mem_we, 0);
        chk("rstw_state_idle", 32'(u_b.state), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
